// File: rtl/adc_frame_packetizer.sv
// Packs one multi-channel ADC sample set into a byte frame
// (SYNC, SEQ, data MSB/LSB per channel, XOR checksum) on an AXI-stream byte source.
module adc_frame_packetizer #(
  parameter int          CHANNELS  = 2,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [16*CHANNELS-1:0]  sample_data,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic [7:0]              source_tdata,
  output logic                    source_tvalid,
  input  logic                    source_tready,
  output logic                    source_tlast,
  output logic [15:0]             dropped_count
);

  localparam int NBYTES = 2 * CHANNELS;
  localparam int IDXW   = $clog2(NBYTES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_SEQ, S_DATA, S_CHK} state_t;

  state_t                  state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic [16*CHANNELS-1:0]  hold_q, hold_d;
  logic [7:0]              seq_q, seq_d;
  logic [7:0]              chk_q, chk_d;
  logic [7:0]              tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic                    ready_q, ready_d;
  logic [15:0]             drop_q, drop_d;
  logic [7:0]              nxt_byte;
  logic                    hs;

  // Byte following the one at idx_q; byte j is the MSB (even j) or LSB of channel j/2.
  always_comb begin
    nxt_byte = '0;
    for (int j = 1; j < NBYTES; j++)
      if (idx_q == IDXW'(j - 1)) nxt_byte = hold_q[8*(j^1) +: 8];
  end

  always_comb begin
    hs       = tvalid_q && source_tready;
    state_d  = state_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    seq_d    = seq_q;
    chk_d    = chk_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    drop_d   = drop_q;

    if (sample_valid && !ready_q && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;

    // Outputs are only ever reloaded on an accept or a handshake, so they hold while stalled.
    case (state_q)
      S_IDLE: if (sample_valid && ready_q) begin
        hold_d   = sample_data;
        state_d  = S_SYNC;
        tvalid_d = 1'b1;
        tdata_d  = SYNC_BYTE;
      end
      S_SYNC: if (hs) begin
        state_d = S_SEQ;
        tdata_d = seq_q;
      end
      S_SEQ: if (hs) begin
        chk_d   = seq_q;
        state_d = S_DATA;
        idx_d   = '0;
        tdata_d = hold_q[15:8];
      end
      S_DATA: if (hs) begin
        chk_d = chk_q ^ tdata_q;
        if (idx_q == LAST_IDX) begin
          state_d = S_CHK;
          idx_d   = '0;
          tdata_d = chk_d;
          tlast_d = 1'b1;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          tdata_d = nxt_byte;
        end
      end
      S_CHK: if (hs) begin
        state_d  = S_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        tdata_d  = '0;
        seq_d    = seq_q + 8'd1;
        chk_d    = '0;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      hold_q   <= '0;
      seq_q    <= '0;
      chk_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      ready_q  <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      seq_q    <= seq_d;
      chk_q    <= chk_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      ready_q  <= ready_d;
      drop_q   <= drop_d;
    end
  end

  assign sample_ready  = ready_q;
  assign source_tdata  = tdata_q;
  assign source_tvalid = tvalid_q;
  assign source_tlast  = tlast_q;
  assign dropped_count = drop_q;

endmodule
